// File: rtl/cve2_rf_rd_sb.sv
// Integer register file (two combinational read ports, one WB write port) with a single-entry load scoreboard.
// Latency: reads are 0 cycles, and a same-cycle WB write is bypassed; writes and scoreboard updates land at the clock edge.
// Backpressure: stall_rd_o holds ID while a read hits an outstanding load; there is no other flow control.
module cve2_rf_rd_sb #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned PerfCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4:0]              rf_raddr_a_i,
  input  logic                    rf_ren_a_i,
  output logic [31:0]             rf_rdata_a_o,
  input  logic [4:0]              rf_raddr_b_i,
  input  logic                    rf_ren_b_i,
  output logic [31:0]             rf_rdata_b_o,
  input  logic [4:0]              rf_waddr_wb_i,
  input  logic [31:0]             rf_wdata_wb_i,
  input  logic                    rf_we_wb_i,
  input  logic                    load_issue_i,
  input  logic [4:0]              load_waddr_i,
  input  logic                    lsu_resp_valid_i,
  input  logic                    lsu_resp_err_i,
  output logic                    stall_rd_o,
  output logic                    load_pending_o,
  output logic [PerfCntWidth-1:0] stall_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } sb_state_e;

  logic [31:0]             r_regs [32];
  sb_state_e               r_state;
  sb_state_e               w_state_nxt;
  logic [4:0]              r_pend_addr;
  logic [4:0]              w_pend_addr_nxt;
  logic [PerfCntWidth-1:0] r_stall_cnt;
  logic                    w_we_ok;
  logic [31:0]             w_rdata_a;
  logic [31:0]             w_rdata_b;
  logic                    w_hit_a;
  logic                    w_hit_b;
  logic                    w_stall;

  // In RV32E, addresses with bit 4 set do not exist: they read 0 and are never written.
  function automatic logic addr_ok(input logic [4:0] addr);
    return !(RV32E && addr[4]);
  endfunction

  assign w_we_ok = rf_we_wb_i && addr_ok(rf_waddr_wb_i) && (rf_waddr_wb_i != 5'd0);

  // Register array: cleared on reset, written from WB. Entry 0 is never written, so x0 stays 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_we_ok) begin
      r_regs[rf_waddr_wb_i] <= rf_wdata_wb_i;
    end
  end

  // Port A read: x0 and nonexistent registers read 0, and a same-cycle WB write is forwarded.
  always_comb begin
    w_rdata_a = 32'd0;
    if (addr_ok(rf_raddr_a_i) && (rf_raddr_a_i != 5'd0)) begin
      if (w_we_ok && (rf_waddr_wb_i == rf_raddr_a_i)) begin
        w_rdata_a = rf_wdata_wb_i;
      end else begin
        w_rdata_a = r_regs[rf_raddr_a_i];
      end
    end
  end

  // Port B read: same rules as port A, bypassed independently.
  always_comb begin
    w_rdata_b = 32'd0;
    if (addr_ok(rf_raddr_b_i) && (rf_raddr_b_i != 5'd0)) begin
      if (w_we_ok && (rf_waddr_wb_i == rf_raddr_b_i)) begin
        w_rdata_b = rf_wdata_wb_i;
      end else begin
        w_rdata_b = r_regs[rf_raddr_b_i];
      end
    end
  end

  assign rf_rdata_a_o = w_rdata_a;
  assign rf_rdata_b_o = w_rdata_b;

  // Scoreboard state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_pend_addr <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  // Scoreboard next state. A response frees the entry. An issue in that same cycle re-arms it.
  // An issue while pending with no response is illegal and is ignored.
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_addr_nxt = r_pend_addr;
    unique case (r_state)
      IDLE: begin
        if (load_issue_i) begin
          w_state_nxt     = PEND;
          w_pend_addr_nxt = load_waddr_i;
        end
      end
      PEND: begin
        if (lsu_resp_valid_i) begin
          if (load_issue_i) begin
            w_pend_addr_nxt = load_waddr_i;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Load-use hazard. The stall drops in the response cycle because data (if any) arrives via the WB bypass.
  assign w_hit_a = rf_ren_a_i && (rf_raddr_a_i == r_pend_addr);
  assign w_hit_b = rf_ren_b_i && (rf_raddr_b_i == r_pend_addr);
  assign w_stall = (r_state == PEND) && !lsu_resp_valid_i && (r_pend_addr != 5'd0) && (w_hit_a || w_hit_b);

  assign stall_rd_o     = w_stall;
  assign load_pending_o = (r_state == PEND);

  // Saturating count of stall cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

  // Protocol checks. An error response must also be a response, so the error flag itself needs no datapath.
  a_no_issue_while_pend: assert property (@(posedge clk_i) disable iff (rst_i)
    ((r_state == PEND) && load_issue_i) |-> lsu_resp_valid_i);
  a_no_resp_while_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == IDLE) |-> !lsu_resp_valid_i);
  a_err_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_resp_err_i |-> lsu_resp_valid_i);

endmodule

// File: doc/cve2_rf_rd_sb.md
Name: cve2_rf_rd_sb

Overview:
- Register-file read side paired with the writeback passthrough. Holds the architectural integer registers, written from the WB port. Serves two combinational read ports to ID, with same-cycle WB-to-read bypass.
- Contains a single-entry load scoreboard. It stalls ID reads of a register whose load is still outstanding in the LSU, and keeps a saturating load-use stall counter.

Parameters:
RV32E, 0, 1 = 16 registers (x0..x15); addresses with bit 4 set read 0 and their writes are dropped; 0 = 32 registers
PerfCntWidth, 16, width of the stall-cycle counter (legal 1..32)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
rf_raddr_a_i  input  5  read port A address
rf_ren_a_i  input  1  port A operand used by current ID instruction
rf_rdata_a_o  output  32  port A data
rf_raddr_b_i  input  5  read port B address
rf_ren_b_i  input  1  port B operand used
rf_rdata_b_o  output  32  port B data
rf_waddr_wb_i  input  5  write address from writeback
rf_wdata_wb_i  input  32  write data from writeback
rf_we_wb_i  input  1  write enable from writeback
load_issue_i  input  1  ID issues a load this cycle
load_waddr_i  input  5  destination of the issued load
lsu_resp_valid_i  input  1  LSU response this cycle (load completes)
lsu_resp_err_i  input  1  LSU response is an error
stall_rd_o  output  1  load-use hazard, ID must hold
load_pending_o  output  1  scoreboard state is PEND
stall_cnt_o  output  PerfCntWidth  saturating count of stall_rd_o cycles

Behaviour:
- Reset (rst_i=1 at clock edge):
  - all registers cleared to 0, state IDLE, pend_addr 0, counter 0.
  - Hence after reset: rdata_* = 0, stall_rd_o = 0, load_pending_o = 0, stall_cnt_o = 0.
  - Reset wins over every simultaneous event, including mid-PEND: the load is dropped.
- x0 (address 0):
  - always reads 0; writes are ignored.
  - never bypassed; never hazards.
- Write: when rf_we_wb_i=1 and the address is valid and nonzero, the register is updated at the clock edge.
- Read: combinational from the register array.
- Bypass: if rf_we_wb_i=1 and rf_waddr_wb_i == raddr (nonzero, valid), rdata = rf_wdata_wb_i in the same cycle. This makes read latency 0 even for the write cycle. Both ports are bypassed independently.
- Scoreboard FSM:
  - IDLE -> PEND on load_issue_i=1; latch pend_addr = load_waddr_i. x0 loads still enter PEND.
  - PEND -> IDLE on lsu_resp_valid_i=1, with or without error.
  - PEND with lsu_resp_valid_i=1 and load_issue_i=1 in the same cycle: stay PEND, pend_addr = new load_waddr_i.
  - PEND with load_issue_i=1 and no response: protocol violation (assertion fires); the issue is ignored and pend_addr is kept.
- Hazard:
  - stall_rd_o = PEND & ~lsu_resp_valid_i & (pend_addr != 0) & ((rf_ren_a_i & raddr_a == pend_addr) | (rf_ren_b_i & raddr_b == pend_addr)).
  - Comparisons use the full 5 bits.
  - On the response cycle the stall drops. Load data arrives through the WB bypass on that same cycle.
  - On an error response the stall still drops. The register keeps its old value and the controller flushes ID.
  - Address compares with rf_ren_*=0 never stall.
- Counter:
  - stall_cnt_o increments by 1 at each edge where stall_rd_o=1.
  - It saturates at all-ones and does not wrap.
- Assertions:
  - no load_issue_i in PEND without lsu_resp_valid_i.
  - no lsu_resp_valid_i in IDLE.

Test Plan:
- Reset then read x5/x31 on A/B -> rdata_a=0, rdata_b=0, stall_rd_o=0, stall_cnt_o=0, load_pending_o=0.
- WB write x7=0xDEADBEEF while raddr_a=7 -> rdata_a=0xDEADBEEF in the same cycle. Next cycle with we=0 -> still 0xDEADBEEF. Write to x0=0x1234 -> x0 reads 0.
- Load-use:
  - load_issue_i, waddr=3 -> load_pending_o=1.
  - Next 3 cycles ren_b=1, raddr_b=3 -> stall_rd_o=1 each cycle.
  - Then resp_valid, err=0 with WB x3=0x55 -> stall_rd_o=0, rdata_b=0x55, stall_cnt_o=3, IDLE.
- Error response: pend x9, resp_valid with err=1, no WB -> stall drops, x9 keeps its prior value, state IDLE. Load to x0, then read x0 -> no stall.
- Back-to-back loads:
  - In the response cycle of load x4, issue load x6 -> stays PEND, pend_addr=6.
  - Read x4 -> no stall. Read x6 -> stall.
  - rst_i mid-PEND -> IDLE, registers 0.
- PerfCntWidth=2, hold the hazard for 5 cycles -> counter reads 1,2,3,3,3. RV32E=1: write x20 -> ignored, read x20 -> 0.
